store_subword_writer: RTL and testbench

- Store-side counterpart of the load-path sign extender in KGP-miniRISC.
- Takes a store request (address, 32-bit data, size) from the MEM stage and truncates the data to byte, halfword or word.
- Byte and halfword stores are merged into the existing 32-bit memory word by a read-modify-write sequence on a synchronous single-port data RAM.
- Word stores are written directly.

---
 rtl/store_subword_writer_pkg.sv | 22 ++
 rtl/subword_merge.sv | 34 +++
 rtl/store_subword_writer.sv | 119 +++++++++++
 tb/tb_store_subword_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_subword_writer_pkg.sv
// Shared miniRISC store-path definitions: access-size encodings and writer FSM states.
// Purely declarative; no logic, no latency, no flow control.
package store_subword_writer_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } sz_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_FIN
   } state_t;

   localparam int CNT_W = 2;

endpackage

// File: rtl/subword_merge.sv
// Little-endian merge of store data into an existing 32-bit word; word size passes data through.
// Combinational, zero latency, no flow control.
module subword_merge
   import store_subword_writer_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] st_data,
   input  sz_t         size,
   input  logic [1:0]  addr_lo,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: begin
            case (addr_lo)
               2'd0:    merged[7:0]   = st_data[7:0];
               2'd1:    merged[15:8]  = st_data[7:0];
               2'd2:    merged[23:16] = st_data[7:0];
               default: merged[31:24] = st_data[7:0];
            endcase
         end
         // addr_lo[0] is ignored here; misaligned halves are trapped upstream when enabled
         SZ_HALF: begin
            if (addr_lo[1]) merged[31:16] = st_data[15:0];
            else            merged[15:0]  = st_data[15:0];
         end
         SZ_WORD: merged = st_data;
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/store_subword_writer.sv
// Store writer: word stores direct, byte/half via RAM read-modify-write; MISALIGN_TRAP_EN traps misaligned stores.
// Latency accept->done: word/trap 1, subword 2+RD_LAT; st_ready high only in IDLE.
module store_subword_writer
   import store_subword_writer_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [1:0]        st_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              err
);

   typedef struct packed {
      logic [1:0]  lane;
      logic [31:0] data;
      sz_t         size;
   } req_t;

   state_t            state, state_nx;
   req_t              req;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              trap;
   logic              wait_last;
   sz_t               st_sz;
   logic [31:0]       merged;

   assign st_sz     = sz_t'(st_size);
   assign accept    = st_valid && (state == S_IDLE);
   assign wait_last = (state == S_WAIT) && (cnt == CNT_W'(RD_LAT - 1));

   always_comb begin
      trap = (st_sz == SZ_RSVD);
`ifdef MISALIGN_TRAP_EN
      if ((st_sz == SZ_HALF && st_addr[0]) ||
          (st_sz == SZ_WORD && st_addr[1:0] != 2'b00))
         trap = 1'b1;
`endif
   end

   always_comb begin
      state_nx  = state;
      st_ready  = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: begin
            st_ready = 1'b1;
            if (st_valid) begin
               if (trap)                  state_nx = S_FIN;
               else if (st_sz == SZ_WORD) state_nx = S_WR;
               else                       state_nx = S_RD;
            end
         end
         S_RD: begin
            mem_rd_en = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: begin
            if (wait_last) state_nx = S_WR;
         end
         S_WR: begin
            mem_wr_en = 1'b1;
            done      = 1'b1;
            state_nx  = S_IDLE;
         end
         S_FIN: begin
            done     = 1'b1;
            err      = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   subword_merge u_merge (
      .old_word (mem_rdata),
      .st_data  (req.data),
      .size     (req.size),
      .addr_lo  (req.lane),
      .merged   (merged)
   );

   // mem_addr/mem_wdata only move when a RAM access is about to happen, so they hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         req       <= '0;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            req <= '{lane: st_addr[1:0], data: st_data, size: st_sz};
            if (!trap) mem_addr <= {st_addr[ADDR_W-1:2], 2'b00};
            if (!trap && st_sz == SZ_WORD) mem_wdata <= st_data;
         end
         if (state == S_RD)        cnt <= '0;
         else if (state == S_WAIT) cnt <= cnt + 1'b1;
         if (wait_last) mem_wdata <= merged;
      end
   end

endmodule

// File: tb/tb_store_subword_writer.sv
// Randomized and directed checks of store_subword_writer against a byte-mask reference model and a RAM model.
// Latency: bench only, checks done timing per access size.
// Backpressure: waits on st_ready with a bounded timeout, holds st_valid across back-to-back stores.
module tb_store_subword_writer;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    store_subword_writer #(.ADDR_W(32), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(int i);
        case (i)
            1:       return 32'hAAAABBBB;
            8:       return 32'h11223344;
            default: return (i * 32'h9E3779B9) ^ 32'h13579BDF;
        endcase
    endfunction

    logic [31:0] ram [64];
    logic [31:0] pipe [RD_LAT];
    logic [31:0] wdat_q [$];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap = 0;
    logic [31:0] last_raddr = '0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    assign mem_rdata = pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (mem_wr_en) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
        if (mem_wr_en) begin
            wr_cnt++;
            wdat_q.push_back(mem_wdata);
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_rd_en) begin
            rd_cnt++;
            last_raddr = mem_addr;
            pipe[0] <= ram[mem_addr[7:2]];
        end else begin
            pipe[0] <= $urandom;
        end
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) if (mem_rd_en && mem_wr_en) overlap++;

    logic [31:0] ref_mem [64];

    function automatic logic [31:0] model_merge(logic [31:0] old, logic [31:0] a,
                                                logic [31:0] d, logic [1:0] sz);
        int          sh;
        logic [31:0] m;
        case (sz)
            2'd0:    begin sh = 8 * int'(a % 4);        m = 32'h0000_00FF; end
            2'd1:    begin sh = 16 * int'((a / 2) % 2); m = 32'h0000_FFFF; end
            default: begin sh = 0;                      m = 32'hFFFF_FFFF; end
        endcase
        return (old & ~(m << sh)) | ((d & m) << sh);
    endfunction

    function automatic bit model_trap(logic [31:0] a, logic [1:0] sz);
        bit t;
        t = (sz == 2'd3);
`ifdef MISALIGN_TRAP_EN
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) t = 1'b1;
`endif
        return t;
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 20 && !st_ready; k++) @(negedge clk);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input string tag);
        bit          trap;
        int          exp_lat, lat, rd0, wr0;
        logic [31:0] exp_word;
        trap     = model_trap(a, sz);
        exp_lat  = (trap || sz == 2'd2) ? 1 : 2 + RD_LAT;
        exp_word = model_merge(ref_mem[a[7:2]], a, d, sz);
        @(negedge clk);
        wait_ready();
        chk({tag, "_ready"}, st_ready, 1'b1);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_addr  = $urandom;
        st_data  = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, err, trap);
        chk({tag, "_wr_en"}, mem_wr_en, !trap);
        if (!trap) begin
            chk({tag, "_waddr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, "_wdata"}, mem_wdata, exp_word);
            ref_mem[a[7:2]] = exp_word;
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_rd_cnt"}, rd_cnt - rd0, (sz < 2'd2 && !trap) ? 1 : 0);
        chk({tag, "_wr_cnt"}, wr_cnt - wr0, trap ? 0 : 1);
        if (sz < 2'd2 && !trap) chk({tag, "_raddr"}, last_raddr, {a[31:2], 2'b00});
    endtask

    initial begin
        logic [31:0] ba [3];
        logic [31:0] bd [3];
        logic [31:0] ew;
        int          w0;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        do_store(32'h10, 32'hDEADBEEF, 2'd2, "word");
        chk("word_lit", last_wdata, 32'hDEADBEEF);
        do_store(32'h22, 32'h123456AB, 2'd0, "byte");
        chk("byte_lit", last_wdata, 32'h11AB3344);
        chk("byte_lit_addr", last_waddr, 32'h20);
        do_store(32'h06, 32'hFFFFCAFE, 2'd1, "half");
        chk("half_lit", last_wdata, 32'hCAFEBBBB);
        do_store(32'h40, 32'h55555555, 2'd3, "rsvd");
        do_store(32'h03, 32'h0000BEEF, 2'd1, "half_mis");
        do_store(32'h2D, 32'h87654321, 2'd2, "word_mis");

        @(negedge clk);
        wait_ready();
        st_valid = 1'b1; st_addr = 32'h44; st_data = 32'h77; st_size = 2'd0;
        @(posedge clk);
        #1 st_valid = 1'b0;
        @(negedge clk);
        chk("mid_rd_strobe", mem_rd_en, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_ready", st_ready, 1'b1);
        chk("mid_rd_en", mem_rd_en, 1'b0);
        chk("mid_wr_en", mem_wr_en, 1'b0);
        chk("mid_addr", mem_addr, 32'h0);
        chk("mid_wdata", mem_wdata, 32'h0);
        chk("mid_done", done, 1'b0);
        w0 = wr_cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_no_write", wr_cnt, w0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        ba[0] = 32'h30; ba[1] = 32'h31; ba[2] = 32'h33;
        for (int i = 0; i < 3; i++) bd[i] = $urandom;
        w0 = wdat_q.size();
        @(negedge clk);
        st_valid = 1'b1;
        st_size  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            chk("b2b_ready", st_ready, 1'b1);
            st_addr = ba[i];
            st_data = bd[i];
            @(posedge clk);
            #1;
            st_addr = $urandom;
            st_data = $urandom;
            if (i == 2) st_valid = 1'b0;
            @(negedge clk);
            chk("b2b_busy", st_ready, 1'b0);
        end
        wait_ready();
        chk("b2b_writes", wdat_q.size() - w0, 3);
        for (int i = 0; i < 3; i++) begin
            ew = model_merge(ref_mem[ba[i][7:2]], ba[i], bd[i], 2'd0);
            ref_mem[ba[i][7:2]] = ew;
            if (w0 + i < wdat_q.size()) chk("b2b_data", wdat_q[w0 + i], ew);
        end

        for (int n = 0; n < 40; n++)
            do_store($urandom_range(0, 255), $urandom, 2'($urandom_range(0, 3)), "rand");

        chk("strobe_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
